output_reader: RTL and testbench

- Read-side engine for the output buffer SRAM: on a start pulse, sequentially reads LENGTH words from BASE_ADDR.
- Emits the words as a valid/ready stream with a last flag toward the host/DMA path.
- Absorbs the SRAM's one-cycle read latency (registered address, data valid next cycle) with a 2-entry skid FIFO, so back-pressure never drops or duplicates a word.

---
 rtl/output_reader_if.sv | 28 ++
 rtl/output_reader.sv | 146 ++++++++++++++
 tb/tb_output_reader.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/output_reader_if.sv
// Stream bus from output_reader toward the host/DMA path.
//   m_data  : signed stream word
//   m_valid : word present on m_data
//   m_ready : consumer accepts the word this cycle
//   m_last  : final word of the transfer
// master = producer (output_reader), slave = consumer.
interface output_reader_if #(
  parameter int DWIDTH = 16
);
  logic signed [DWIDTH-1:0] m_data;
  logic                     m_valid;
  logic                     m_ready;
  logic                     m_last;

  modport master (
    output m_data,
    output m_valid,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/output_reader.sv
// output_reader: read-side engine for the output buffer SRAM.
// On an accepted start it reads `length` words beginning at `base_addr`
// (address wraps modulo 2**OUTSIZE) and streams them out with a last flag.
// The SRAM's one-cycle read latency is absorbed by a 2-entry skid FIFO, so
// back-pressure on the stream never drops or duplicates a word.
// Ports:
//   clk, xrst           clock (posedge), asynchronous active-low reset
//   start               one-cycle request, ignored while busy
//   base_addr, length   transfer descriptor, latched on accepted start
//   busy, done          transfer in progress / one-cycle completion pulse
//   mem_addr            registered SRAM read address
//   read_data           SRAM data for the address presented last cycle
//   strm                stream bus (m_data, m_valid, m_ready, m_last)
module output_reader #(
  parameter int DWIDTH  = 16,
  parameter int OUTSIZE = 12
) (
  input  logic                      clk,
  input  logic                      xrst,
  input  logic                      start,
  input  logic [OUTSIZE-1:0]        base_addr,
  input  logic [OUTSIZE:0]          length,
  output logic                      busy,
  output logic                      done,
  output logic [OUTSIZE-1:0]        mem_addr,
  input  logic signed [DWIDTH-1:0]  read_data,
  output_reader_if.master           strm
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t state_q, state_d;

  logic [OUTSIZE-1:0] base_q;
  logic [OUTSIZE:0]   len_q;
  logic [OUTSIZE:0]   issued_q;
  logic               in_flight_q;
  logic               flight_last_q;

  logic signed [DWIDTH-1:0] fifo_data [2];
  logic                     fifo_last [2];
  logic                     head_q;
  logic [1:0]               count_q;

  logic       accept;
  logic       pop;
  logic       push;
  logic       issue;
  logic       tail;
  logic [1:0] pending;
  logic       head_last;

  assign accept    = (state_q == S_IDLE) && start;
  assign pop       = (count_q != 2'd0) && strm.m_ready;
  assign push      = in_flight_q;
  assign tail      = head_q ^ count_q[0];
  assign head_last = fifo_last[head_q];

  // Occupancy seen by the issue rule credits a same-cycle pop, which is what
  // keeps the stream at one word per cycle with m_ready held high; the FIFO
  // still cannot overflow because at most one capture lands per cycle.
  assign pending = count_q + {1'b0, in_flight_q} - {1'b0, pop};
  assign issue   = (state_q == S_READ) && (issued_q != len_q) && (pending < 2'd2);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        // A zero-length transfer passes through DRAIN so done lands two
        // cycles after start, the same spacing a normal transfer's tail has.
        if (start) state_d = (length == '0) ? S_DRAIN : S_READ;
      end
      S_READ: begin
        if (issued_q == len_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if ((len_q == '0) || (pop && head_last)) state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      base_q        <= '0;
      len_q         <= '0;
      issued_q      <= '0;
      in_flight_q   <= 1'b0;
      flight_last_q <= 1'b0;
      mem_addr      <= '0;
    end else begin
      if (accept) begin
        base_q   <= base_addr;
        len_q    <= length;
        issued_q <= '0;
      end else if (issue) begin
        issued_q <= issued_q + 1'b1;
      end
      in_flight_q <= issue;
      if (issue) begin
        mem_addr      <= base_q + issued_q[OUTSIZE-1:0];
        flight_last_q <= (issued_q == len_q - 1'b1);
      end
    end
  end

  // Capture writes at head+count (pre-pop), which is the correct tail even
  // when a pop happens in the same cycle.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_last[0] <= 1'b0;
      fifo_last[1] <= 1'b0;
      head_q       <= 1'b0;
      count_q      <= '0;
    end else begin
      if (push) begin
        fifo_data[tail] <= read_data;
        fifo_last[tail] <= flight_last_q;
      end
      if (pop) head_q <= ~head_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign strm.m_valid = (count_q != 2'd0);
  assign strm.m_data  = fifo_data[head_q];
  assign strm.m_last  = strm.m_valid && head_last;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_FIN);

endmodule

// File: tb/tb_output_reader.sv
module tb_output_reader;
  localparam int DW = 16;
  localparam int AW = 12;

  logic                 clk;
  logic                 xrst;
  logic                 start;
  logic [AW-1:0]        base_addr;
  logic [AW:0]          length;
  logic                 busy;
  logic                 done;
  logic [AW-1:0]        mem_addr;
  logic signed [DW-1:0] read_data;

  output_reader_if #(.DWIDTH(DW)) s_if ();

  output_reader #(.DWIDTH(DW), .OUTSIZE(AW)) dut (
    .clk       (clk),
    .xrst      (xrst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .read_data (read_data),
    .strm      (s_if.master)
  );

  logic signed [DW-1:0] mem [4096];
  initial for (int i = 0; i < 4096; i++) mem[i] = DW'(i + 100);
  assign read_data = mem[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic signed [DW-1:0] d;
    logic                 l;
  } exp_t;
  exp_t exp_q[$];

  // m_ready driver
  logic        rdy_fixed = 1'b1;
  logic        pat_en = 1'b0;
  int unsigned pat_idx = 0;
  bit          pat [6] = '{1, 0, 0, 1, 0, 1};
  initial begin
    s_if.m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (pat_en) begin
        s_if.m_ready = pat[pat_idx % 6];
        pat_idx++;
      end else begin
        s_if.m_ready = rdy_fixed;
      end
    end
  end

  // monitor / scoreboard
  int                   hs_cnt = 0;
  int                   done_cnt = 0;
  int                   hs_cyc[$];
  bit                   zero_mode = 0;
  bit                   zero_valid_seen = 0;
  bit                   prev_last_hs = 0;
  bit                   held_valid = 0;
  logic signed [DW-1:0] held_data;
  logic                 held_last;
  initial begin
    forever begin
      @(negedge clk);
      if (!xrst) begin
        held_valid   = 0;
        prev_last_hs = 0;
      end else begin
        if (held_valid)
          chk(s_if.m_valid && s_if.m_data == held_data && s_if.m_last == held_last,
              "stall_stable", s_if.m_data, held_data);
        if (!zero_mode && (done || prev_last_hs))
          chk(done == prev_last_hs, "done_after_last", done, prev_last_hs);
        if (done) done_cnt++;
        if (zero_mode && s_if.m_valid) zero_valid_seen = 1;
        if (s_if.m_valid && s_if.m_ready) begin
          if (exp_q.size() == 0) begin
            chk(0, "extra_beat", s_if.m_data, 0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk(s_if.m_data == e.d, "beat_data", s_if.m_data, e.d);
            chk(s_if.m_last == e.l, "beat_last", s_if.m_last, e.l);
          end
          hs_cnt++;
          hs_cyc.push_back(cyc);
        end
        prev_last_hs = s_if.m_valid && s_if.m_ready && s_if.m_last;
        held_valid   = s_if.m_valid && !s_if.m_ready;
        held_data    = s_if.m_data;
        held_last    = s_if.m_last;
      end
    end
  end

  int start_cyc;

  task automatic push_exp(input int b, input int l);
    for (int i = 0; i < l; i++) begin
      exp_t e;
      e.d = DW'(((b + i) % 4096) + 100);
      e.l = (i == l - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic clear_stats();
    hs_cnt   = 0;
    done_cnt = 0;
    hs_cyc.delete();
  endtask

  task automatic pulse_start(input int b, input int l);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = AW'(b);
    length    = (AW + 1)'(l);
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 300);
    chk(done, name, done, 1);
    @(negedge clk);
    #2;
    chk(!busy, "busy_after_done", busy, 0);
  endtask

  task automatic run_std(input string name, input int b, input int l);
    clear_stats();
    push_exp(b, l);
    pulse_start(b, l);
    wait_done(name);
    chk(exp_q.size() == 0, "all_beats_seen", exp_q.size(), 0);
    chk(hs_cnt == l, "beat_count", hs_cnt, l);
    chk(done_cnt == 1, "done_once", done_cnt, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    int   n;
    logic [AW-1:0] addr0;
    xrst = 1'b0; start = 1'b0; base_addr = '0; length = '0;
    repeat (3) @(negedge clk);
    chk(!busy, "rst_busy", busy, 0);
    chk(!done, "rst_done", done, 0);
    chk(!s_if.m_valid, "rst_valid", s_if.m_valid, 0);
    chk(!s_if.m_last, "rst_last", s_if.m_last, 0);
    chk(mem_addr == 0, "rst_addr", mem_addr, 0);
    chk(s_if.m_data == 0, "rst_data", s_if.m_data, 0);
    xrst = 1'b1;

    // basic transfer, full throughput
    rdy_fixed = 1'b1;
    run_std("t1_done", 5, 4);
    if (hs_cyc.size() == 4) begin
      chk(hs_cyc[0] - start_cyc == 3, "first_beat_latency", hs_cyc[0] - start_cyc, 3);
      chk(hs_cyc[3] - hs_cyc[0] == 3, "consecutive_beats", hs_cyc[3] - hs_cyc[0], 3);
    end

    // back-pressure
    pat_idx = 0;
    pat_en  = 1'b1;
    run_std("t2_done", 5, 4);
    pat_en  = 1'b0;

    // address wrap
    run_std("t3_done", 4094, 4);

    // zero length
    clear_stats();
    zero_mode = 1;
    zero_valid_seen = 0;
    addr0 = mem_addr;
    @(posedge clk);
    #1;
    start = 1'b1; base_addr = AW'(7); length = '0;
    @(negedge clk);
    chk(!done, "zero_done_c0", done, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk(!done && busy, "zero_c1", done, 0);
    @(negedge clk);
    chk(done, "zero_done_c2", done, 1);
    @(negedge clk);
    chk(!done && !busy, "zero_c3", busy, 0);
    repeat (4) @(negedge clk);
    chk(!zero_valid_seen, "zero_no_valid", zero_valid_seen, 0);
    chk(done_cnt == 1, "zero_done_once", done_cnt, 1);
    chk(mem_addr == addr0, "zero_addr_hold", mem_addr, addr0);
    zero_mode = 0;

    // start while busy is ignored
    clear_stats();
    push_exp(5, 4);
    pulse_start(5, 4);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; base_addr = '0; length = (AW + 1)'(3);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("t5_done");
    repeat (3) @(negedge clk);
    chk(!busy, "t5_no_restart", busy, 0);
    chk(hs_cnt == 4, "t5_beats", hs_cnt, 4);
    chk(done_cnt == 1, "t5_done_once", done_cnt, 1);
    chk(exp_q.size() == 0, "t5_all_seen", exp_q.size(), 0);

    // reset mid-transfer
    clear_stats();
    rdy_fixed = 1'b1;
    push_exp(5, 4);
    pulse_start(5, 4);
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (hs_cnt < 2 && n < 50);
    chk(hs_cnt == 2, "t6_two_beats", hs_cnt, 2);
    rdy_fixed = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    xrst = 1'b0;
    #1;
    chk(!busy && !done, "t6_rst_ctrl", busy, 0);
    chk(!s_if.m_valid && !s_if.m_last, "t6_rst_stream", s_if.m_valid, 0);
    chk(mem_addr == 0, "t6_rst_addr", mem_addr, 0);
    chk(s_if.m_data == 0, "t6_rst_data", s_if.m_data, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    xrst = 1'b1;
    chk(done_cnt == 0, "t6_no_abort_done", done_cnt, 0);
    rdy_fixed = 1'b1;
    repeat (2) @(negedge clk);
    run_std("t6_done", 0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
